multi_alarm_timekeeper: RTL

Parametrised 24-hour timekeeping core with NUM_ALARMS independently armed alarms, snooze and auto-timeout ringing. It replaces the single-alarm clock/alarm/FSM cluster under the board top level. It consumes already-debounced single-cycle button pulses and produces binary h/m/s values for the downstream BCD and 7-segment path.

---
 rtl/clock_pkg.sv | 52 +++++
 rtl/sec_prescaler.sv | 34 +++
 rtl/multi_alarm_timekeeper.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types, field widths and wrap helpers for the multi-alarm timekeeper.
// Times are binary hours/minutes/seconds; alarms and snooze targets are hour:minute pairs.
package clock_pkg;

   localparam int HW = 5;
   localparam int MW = 6;
   localparam int SW = 6;

   localparam logic [HW-1:0] H_MAX = 5'd23;
   localparam logic [MW-1:0] M_MAX = 6'd59;
   localparam logic [SW-1:0] S_MAX = 6'd59;
   localparam logic [MW:0]   MINS_PER_HOUR = 7'd60;

   typedef enum logic [1:0] {
      MODE_RUN       = 2'd0,
      MODE_SET_TIME  = 2'd1,
      MODE_SET_ALARM = 2'd2
   } mode_e;

   typedef enum logic {
      RING_IDLE   = 1'b0,
      RING_ACTIVE = 1'b1
   } ring_e;

   typedef struct packed {
      logic [HW-1:0] h;
      logic [MW-1:0] m;
   } hm_t;

   function automatic logic [HW-1:0] next_hour(input logic [HW-1:0] h);
      return (h >= H_MAX) ? '0 : h + 5'd1;
   endfunction

   function automatic logic [MW-1:0] next_min(input logic [MW-1:0] m);
      return (m >= M_MAX) ? '0 : m + 6'd1;
   endfunction

   // Adds dm (< 60) minutes; a minute overflow carries into the hour, which wraps at 24.
   function automatic hm_t add_minutes(input hm_t t, input logic [MW-1:0] dm);
      hm_t           r;
      logic [MW:0]   sum;
      sum = {1'b0, t.m} + {1'b0, dm};
      r.h = t.h;
      if (sum >= MINS_PER_HOUR) begin
         sum = sum - MINS_PER_HOUR;
         r.h = next_hour(t.h);
      end
      r.m = sum[MW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// tick is high while the counter sits at terminal count; clr restarts the second.
module sec_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic RESETn,
   input  logic clr,
   output logic tick
);

   localparam int            CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// 24-hour timekeeper with NUM_ALARMS armed alarm slots, per-slot snooze and timed ringing.
// Buttons are single-cycle pulses; every held-high cycle counts as another press.
module multi_alarm_timekeeper
   import clock_pkg::*;
#(
   parameter  int NUM_ALARMS = 4,
   parameter  int TICK_DIV   = 50_000_000,
   parameter  int RING_SECS  = 60,
   parameter  int SNOOZE_MIN = 5,
   localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  RESETn,
   input  logic                  mode_btn,
   input  logic                  inc_sec,
   input  logic                  inc_min,
   input  logic                  inc_hour,
   input  logic [AW-1:0]         alarm_sel,
   input  logic [NUM_ALARMS-1:0] alarm_arm,
   input  logic                  snooze,
   input  logic                  stop,
   output logic [HW-1:0]         time_h,
   output logic [MW-1:0]         time_m,
   output logic [SW-1:0]         time_s,
   output logic [HW-1:0]         disp_h,
   output logic [MW-1:0]         disp_m,
   output logic [SW-1:0]         disp_s,
   output logic [1:0]            mode,
   output logic                  sec_pulse,
   output logic                  ringing,
   output logic [AW-1:0]         ring_idx
);

   logic                  tick;
   logic                  presc_clr;
   logic                  btn_mode;
   logic                  adv;
   logic                  edit_alarm;
   logic                  match_any;
   logic                  match_by_snz;
   logic [AW-1:0]         match_idx;
   hm_t                   now_hm;
   hm_t                   sel_alarm;

   mode_e                 mode_q, mode_d;
   logic [HW-1:0]         time_h_q, time_h_d;
   logic [MW-1:0]         time_m_q, time_m_d;
   logic [SW-1:0]         time_s_q, time_s_d;
   logic                  sec_pulse_q, sec_pulse_d;
   hm_t                   alarm_q   [NUM_ALARMS];
   hm_t                   alarm_d   [NUM_ALARMS];
   hm_t                   snz_tgt_q [NUM_ALARMS];
   hm_t                   snz_tgt_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] snz_flag_q, snz_flag_d;
   ring_e                 ring_q, ring_d;
   logic [AW-1:0]         ring_idx_q, ring_idx_d;
   logic [7:0]            ring_cnt_q, ring_cnt_d;

   sec_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .RESETn (RESETn),
      .clr    (presc_clr),
      .tick   (tick)
   );

   assign now_hm = '{h: time_h_q, m: time_m_q};

   // While ringing, mode_btn is swallowed as a stop request.
   always_comb begin
      btn_mode = mode_btn && (ring_q == RING_IDLE);
      mode_d   = mode_q;
      if (btn_mode) begin
         case (mode_q)
            MODE_RUN:      mode_d = MODE_SET_TIME;
            MODE_SET_TIME: mode_d = MODE_SET_ALARM;
            default:       mode_d = MODE_RUN;
         endcase
      end
      presc_clr   = btn_mode && (mode_q == MODE_RUN);
      adv         = tick && (mode_q != MODE_SET_TIME) && (mode_d != MODE_SET_TIME);
      sec_pulse_d = adv && (mode_q == MODE_RUN) && (mode_d == MODE_RUN);
   end

   always_comb begin
      time_h_d = time_h_q;
      time_m_d = time_m_q;
      time_s_d = time_s_q;
      if (adv) begin
         time_s_d = next_min(time_s_q);
         if (time_s_q == S_MAX) begin
            time_m_d = next_min(time_m_q);
            if (time_m_q == M_MAX) begin
               time_h_d = next_hour(time_h_q);
            end
         end
      end else if (mode_q == MODE_SET_TIME) begin
         if (inc_sec)  time_s_d = next_min(time_s_q);
         if (inc_min)  time_m_d = next_min(time_m_q);
         if (inc_hour) time_h_d = next_hour(time_h_q);
      end
   end

   // Lowest-index slot wins the match; losers are dropped, not queued.
   always_comb begin
      match_any    = 1'b0;
      match_by_snz = 1'b0;
      match_idx    = '0;
      if (sec_pulse_q && (time_s_q == '0)) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (!match_any &&
                ((alarm_arm[i] && (alarm_q[i] == now_hm)) ||
                 (snz_flag_q[i] && (snz_tgt_q[i] == now_hm)))) begin
               match_any    = 1'b1;
               match_idx    = AW'(i);
               match_by_snz = snz_flag_q[i] && (snz_tgt_q[i] == now_hm);
            end
         end
      end
   end

   always_comb begin
      alarm_d    = alarm_q;
      snz_tgt_d  = snz_tgt_q;
      snz_flag_d = snz_flag_q;
      ring_d     = ring_q;
      ring_idx_d = ring_idx_q;
      ring_cnt_d = ring_cnt_q;
      edit_alarm = (mode_q == MODE_SET_ALARM) && (inc_min || inc_hour);

      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (edit_alarm && (alarm_sel == AW'(i))) begin
            if (inc_hour) alarm_d[i].h = next_hour(alarm_q[i].h);
            if (inc_min)  alarm_d[i].m = next_min(alarm_q[i].m);
            snz_flag_d[i] = 1'b0;
         end
      end

      case (ring_q)
         RING_IDLE: begin
            if (match_any) begin
               ring_d     = RING_ACTIVE;
               ring_idx_d = match_idx;
               ring_cnt_d = 8'(RING_SECS);
               for (int i = 0; i < NUM_ALARMS; i++) begin
                  if (match_by_snz && (match_idx == AW'(i))) snz_flag_d[i] = 1'b0;
               end
            end
         end
         RING_ACTIVE: begin
            if (stop || mode_btn) begin
               ring_d = RING_IDLE;
            end else if (snooze) begin
               ring_d = RING_IDLE;
               for (int i = 0; i < NUM_ALARMS; i++) begin
                  if (ring_idx_q == AW'(i)) begin
                     snz_flag_d[i] = 1'b1;
                     snz_tgt_d[i]  = add_minutes(now_hm, MW'(SNOOZE_MIN));
                  end
               end
            end else if (tick) begin
               if (ring_cnt_q <= 8'd1) begin
                  ring_d     = RING_IDLE;
                  ring_cnt_d = '0;
               end else begin
                  ring_cnt_d = ring_cnt_q - 8'd1;
               end
            end
         end
         default: ring_d = RING_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         mode_q      <= MODE_RUN;
         time_h_q    <= '0;
         time_m_q    <= '0;
         time_s_q    <= '0;
         sec_pulse_q <= 1'b0;
         snz_flag_q  <= '0;
         ring_q      <= RING_IDLE;
         ring_idx_q  <= '0;
         ring_cnt_q  <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_q[i]   <= '0;
            snz_tgt_q[i] <= '0;
         end
      end else begin
         mode_q      <= mode_d;
         time_h_q    <= time_h_d;
         time_m_q    <= time_m_d;
         time_s_q    <= time_s_d;
         sec_pulse_q <= sec_pulse_d;
         snz_flag_q  <= snz_flag_d;
         ring_q      <= ring_d;
         ring_idx_q  <= ring_idx_d;
         ring_cnt_q  <= ring_cnt_d;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_q[i]   <= alarm_d[i];
            snz_tgt_q[i] <= snz_tgt_d[i];
         end
      end
   end

   always_comb begin
      sel_alarm = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (alarm_sel == AW'(i)) sel_alarm = alarm_q[i];
      end
      disp_h = time_h_q;
      disp_m = time_m_q;
      disp_s = time_s_q;
      if (mode_q == MODE_SET_ALARM) begin
         disp_h = sel_alarm.h;
         disp_m = sel_alarm.m;
         disp_s = '0;
      end
   end

   assign time_h    = time_h_q;
   assign time_m    = time_m_q;
   assign time_s    = time_s_q;
   assign mode      = mode_q;
   assign sec_pulse = sec_pulse_q;
   assign ringing   = (ring_q == RING_ACTIVE);
   assign ring_idx  = ring_idx_q;

endmodule
